hack_decode_stage: RTL and testbench

- Pipeline stage directly downstream of the program ROM fetch stage in the Hack CPU.
- Captures the 16-bit instruction word from the synchronous ROM and tracks the PC of that word.
- Decodes the word into A/C-instruction control fields for execute, and squashes wrong-path words after a jump.
- Generates the jump and stall controls that drive the fetch stage; inserts a one-bubble stall for C-instructions that read M.

---
 rtl/hack_decode_stage.sv | 206 ++++++++++++++++++++
 tb/tb_hack_decode_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_decode_stage.sv
// Hack CPU decode stage: captures ROM words, tracks their PC, decodes A/C fields and steers fetch.
// Optional illegal-C-instruction trap enabled by defining HACK_DECODE_ILLEGAL_TRAP_EN.
module hack_decode_stage #(
  parameter logic [14:0] RESET_PC    = 15'd0,
  parameter bit          MREAD_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rom_instr,
  input  logic        ex_jmp,
  input  logic [14:0] ex_target,
  input  logic        ex_hold,
  output logic        fetch_jmp,
  output logic [14:0] fetch_addr,
  output logic        fetch_stall,
  output logic        dec_valid,
  output logic [14:0] dec_pc,
  output logic        dec_is_c,
  output logic [14:0] dec_a_val,
  output logic        dec_a_sel_m,
  output logic [5:0]  dec_alu,
  output logic [2:0]  dec_dest,
  output logic [2:0]  dec_jcond,
  output logic        dec_mem_rd,
  output logic        dec_mem_wr
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
  ,
  output logic        dec_illegal
`endif
);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_RUN,
    ST_SQUASH,
    ST_MSTALL,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [14:0] pc;
    logic        is_c;
    logic [14:0] a_val;
    logic        a_sel_m;
    logic [5:0]  alu;
    logic [2:0]  dest;
    logic [2:0]  jcond;
    logic        mem_rd;
    logic        mem_wr;
  } dec_t;

  state_t      state_q, state_d;
  logic [14:0] pc_q, pc_d;
  logic [15:0] skid_q, skid_d;
  dec_t        dec_q, dec_d;
  logic        stall_req;
  logic        issue_en;
  logic [15:0] issue_word;
  logic        mread_hit;
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
  logic        illegal_q, illegal_d;
`endif

  function automatic dec_t decode_word(input logic [15:0] w, input logic [14:0] pc);
    dec_t d;
    d       = '0;
    d.valid = 1'b1;
    d.pc    = pc;
    d.is_c  = w[15];
    if (w[15]) begin
      d.a_sel_m = w[12];
      d.alu     = w[11:6];
      d.dest    = w[5:3];
      d.jcond   = w[2:0];
      d.mem_rd  = w[12];
      d.mem_wr  = w[3];
    end else begin
      d.a_val = w[14:0];
    end
    return d;
  endfunction

  // A C-instruction reading M needs one bubble so the RAM read can settle.
  if (MREAD_STALL) begin : g_mread
    assign mread_hit = rom_instr[15] & rom_instr[12];
  end else begin : g_no_mread
    assign mread_hit = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    dec_d      = dec_q;
    stall_req  = 1'b0;
    issue_en   = 1'b0;
    issue_word = rom_instr;
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    if (ex_jmp) begin
      // A taken jump beats everything: drop the pending word and refetch from target.
      dec_d   = '0;
      skid_d  = '0;
      pc_d    = ex_target;
      state_d = ST_SQUASH;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          dec_d   = '0;
          state_d = ST_RUN;
        end
        ST_RUN, ST_SQUASH: begin
          if (ex_hold) begin
            skid_d  = rom_instr;
            state_d = ST_HOLD;
          end else if (mread_hit) begin
            stall_req = 1'b1;
            dec_d     = '0;
            skid_d    = rom_instr;
            state_d   = ST_MSTALL;
          end else begin
            issue_en = 1'b1;
            state_d  = ST_RUN;
          end
        end
        ST_MSTALL: begin
          if (ex_hold) begin
            state_d = ST_HOLD;
          end else begin
            issue_en   = 1'b1;
            issue_word = skid_q;
            state_d    = ST_RUN;
          end
        end
        ST_HOLD: begin
          // Keep fetch parked through the release cycle so the word after the skid is not lost.
          stall_req = 1'b1;
          if (!ex_hold) begin
            issue_en   = 1'b1;
            issue_word = skid_q;
            state_d    = ST_RUN;
          end
        end
        default: begin
          dec_d   = '0;
          state_d = ST_FILL;
        end
      endcase
    end

    if (issue_en) begin
      pc_d = pc_q + 15'd1;
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
      if (issue_word[15] && (issue_word[14:13] != 2'b11)) begin
        dec_d     = '0;
        illegal_d = 1'b1;
      end else begin
        dec_d = decode_word(issue_word, pc_q);
      end
`else
      dec_d = decode_word(issue_word, pc_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FILL;
      pc_q      <= RESET_PC;
      skid_q    <= '0;
      dec_q     <= '0;
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      skid_q    <= skid_d;
      dec_q     <= dec_d;
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign fetch_jmp   = ex_jmp & ~reset;
  assign fetch_addr  = reset ? 15'd0 : ex_target;
  assign fetch_stall = stall_req & ~reset;

  assign dec_valid   = dec_q.valid;
  assign dec_pc      = dec_q.pc;
  assign dec_is_c    = dec_q.is_c;
  assign dec_a_val   = dec_q.a_val;
  assign dec_a_sel_m = dec_q.a_sel_m;
  assign dec_alu     = dec_q.alu;
  assign dec_dest    = dec_q.dest;
  assign dec_jcond   = dec_q.jcond;
  assign dec_mem_rd  = dec_q.mem_rd;
  assign dec_mem_wr  = dec_q.mem_wr;
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
  assign dec_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_hack_decode_stage.sv
// Bench for hack_decode_stage: cycle table, directed corner sequences, then random traffic
// against a program-order model (next PC to issue, redirected by jumps).
module tb_hack_decode_stage;

  localparam logic [14:0] RST_PC = 15'd0;

  typedef struct packed {
    logic        valid;
    logic [14:0] pc;
    logic        is_c;
    logic [14:0] a_val;
    logic        a_sel_m;
    logic [5:0]  alu;
    logic [2:0]  dest;
    logic [2:0]  jcond;
    logic        mem_rd;
    logic        mem_wr;
  } dec_s;

  typedef struct {
    logic        rst;
    logic        jmp;
    logic [14:0] tgt;
    logic        hold;
    logic        exp_stall;
    logic        exp_fjmp;
    logic        exp_valid;
    logic [14:0] exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rom_instr;
  logic        ex_jmp;
  logic [14:0] ex_target;
  logic        ex_hold;
  logic        fetch_jmp;
  logic [14:0] fetch_addr;
  logic        fetch_stall;
  logic        dec_valid;
  logic [14:0] dec_pc;
  logic        dec_is_c;
  logic [14:0] dec_a_val;
  logic        dec_a_sel_m;
  logic [5:0]  dec_alu;
  logic [2:0]  dec_dest;
  logic [2:0]  dec_jcond;
  logic        dec_mem_rd;
  logic        dec_mem_wr;
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
  logic        dec_illegal;
`endif

  always #5 clk = ~clk;

  hack_decode_stage #(.RESET_PC(RST_PC), .MREAD_STALL(1'b1)) dut (
    .clk(clk), .reset(reset), .rom_instr(rom_instr), .ex_jmp(ex_jmp),
    .ex_target(ex_target), .ex_hold(ex_hold), .fetch_jmp(fetch_jmp),
    .fetch_addr(fetch_addr), .fetch_stall(fetch_stall), .dec_valid(dec_valid),
    .dec_pc(dec_pc), .dec_is_c(dec_is_c), .dec_a_val(dec_a_val),
    .dec_a_sel_m(dec_a_sel_m), .dec_alu(dec_alu), .dec_dest(dec_dest),
    .dec_jcond(dec_jcond), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr)
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
    , .dec_illegal(dec_illegal)
`endif
  );

  // Fetch stage + synchronous ROM: word for the presented address arrives next cycle.
  logic [15:0] rom [32768];
  logic [14:0] last_addr;
  logic [14:0] pres_addr;

  always_comb begin
    pres_addr = fetch_jmp ? fetch_addr : (fetch_stall ? last_addr : last_addr + 15'd1);
  end

  always @(posedge clk) begin
    if (reset) last_addr <= RST_PC - 15'd1;
    else       last_addr <= pres_addr;
    rom_instr <= rom[pres_addr];
  end

  int   errors = 0;
  int   checks = 0;
  logic fstall_pre, fjmp_pre;
  logic [14:0] faddr_pre;
  dec_s prev_dec;
  vec_t vecs[$];

  function automatic dec_s ref_dec(input logic [15:0] w, input logic [14:0] pc);
    dec_s d;
    d       = '0;
    d.valid = 1'b1;
    d.pc    = pc;
    if (!w[15]) begin
      d.a_val = w[14:0];
    end else begin
      d.is_c    = 1'b1;
      d.a_sel_m = w[12];
      d.alu     = w[11:6];
      d.dest    = w[5:3];
      d.jcond   = w[2:0];
      d.mem_rd  = w[12];
      d.mem_wr  = w[3];
    end
    return d;
  endfunction

  function automatic dec_s cur_dec();
    dec_s d;
    d = {dec_valid, dec_pc, dec_is_c, dec_a_val, dec_a_sel_m, dec_alu,
         dec_dest, dec_jcond, dec_mem_rd, dec_mem_wr};
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic j, input logic [14:0] t, input logic h);
    prev_dec  = cur_dec();
    reset     = r;
    ex_jmp    = j;
    ex_target = t;
    ex_hold   = h;
    #1;
    fstall_pre = fetch_stall;
    fjmp_pre   = fetch_jmp;
    faddr_pre  = fetch_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic j, input logic [14:0] t, input logic h,
                     input logic es, input logic ej, input logic ev, input logic [14:0] epc);
    vec_t v;
    v.rst = r; v.jmp = j; v.tgt = t; v.hold = h;
    v.exp_stall = es; v.exp_fjmp = ej; v.exp_valid = ev; v.exp_pc = epc;
    vecs.push_back(v);
  endtask

  initial begin
    logic [14:0] next_pc;
    logic [15:0] w;
    logic        r, j, h;
    logic [14:0] t;
    int          issued;

    reset = 1'b1; ex_jmp = 1'b0; ex_target = '0; ex_hold = 1'b0;
    for (int i = 0; i < 32768; i++) rom[i] = {1'b0, 15'(i)};
    rom[0]     = 16'h0005;
    rom[1]     = 16'hEC10;
    rom[4]     = 16'hFC10;
    rom[16'h30] = 16'h8000;

    //  rst jmp tgt        hold stall fjmp valid pc
    add(1, 1, 15'h1234, 0,   0, 0, 0, 15'h00);
    add(1, 0, 15'h0000, 0,   0, 0, 0, 15'h00);
    add(0, 0, 15'h0000, 0,   0, 0, 0, 15'h00);  // FILL bubble
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h00);
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h01);
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h02);
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h03);
    add(0, 0, 15'h0000, 0,   1, 0, 0, 15'h00);  // D=M at PC 4 -> one bubble
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h04);
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h05);
    add(0, 1, 15'h0010, 0,   0, 1, 0, 15'h00);  // jump, wrong-path word dropped
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h10);
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h11);
    add(0, 0, 15'h0000, 1,   0, 0, 1, 15'h11);  // hold x3
    add(0, 0, 15'h0000, 1,   1, 0, 1, 15'h11);
    add(0, 0, 15'h0000, 1,   1, 0, 1, 15'h11);
    add(0, 0, 15'h0000, 0,   1, 0, 1, 15'h12);
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h13);
    add(0, 0, 15'h0000, 1,   0, 0, 1, 15'h13);  // hold, then jump during hold
    add(0, 0, 15'h0000, 1,   1, 0, 1, 15'h13);
    add(0, 1, 15'h0020, 1,   0, 1, 0, 15'h00);
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h20);
    add(0, 0, 15'h0000, 0,   0, 0, 1, 15'h21);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].jmp, vecs[k].tgt, vecs[k].hold);
      $display("vec %0d: rst=%0b jmp=%0b hold=%0b -> stall=%0b valid=%0b pc=%h",
               k, vecs[k].rst, vecs[k].jmp, vecs[k].hold, fstall_pre, dec_valid, dec_pc);
      chk($sformatf("vec%0d fetch_stall", k), 64'(fstall_pre), 64'(vecs[k].exp_stall));
      chk($sformatf("vec%0d fetch_jmp", k), 64'(fjmp_pre), 64'(vecs[k].exp_fjmp));
      if (vecs[k].exp_fjmp)
        chk($sformatf("vec%0d fetch_addr", k), 64'(faddr_pre), 64'(vecs[k].tgt));
      if (vecs[k].rst) begin
        chk($sformatf("vec%0d reset fetch_addr", k), 64'(faddr_pre), 64'(0));
        chk($sformatf("vec%0d reset dec", k), 64'(cur_dec()), 64'(0));
      end
      chk($sformatf("vec%0d dec_valid", k), 64'(dec_valid), 64'(vecs[k].exp_valid));
      if (vecs[k].exp_valid)
        chk($sformatf("vec%0d dec", k), 64'(cur_dec()),
            64'(ref_dec(rom[vecs[k].exp_pc], vecs[k].exp_pc)));
    end

    // PC wrap 0x7FFF -> 0x0000
    step(0, 1, 15'h7FFE, 0);
    chk("wrap bubble", 64'(dec_valid), 64'(0));
    step(0, 0, 15'h0, 0);
    chk("wrap pc7ffe", 64'(cur_dec()), 64'(ref_dec(rom[15'h7FFE], 15'h7FFE)));
    step(0, 0, 15'h0, 0);
    chk("wrap pc7fff", 64'(cur_dec()), 64'(ref_dec(rom[15'h7FFF], 15'h7FFF)));
    step(0, 0, 15'h0, 0);
    chk("wrap pc0000", 64'(dec_pc), 64'(15'h0000));
    chk("wrap valid", 64'(dec_valid), 64'(1));
    $display("seq wrap: last pc=%h", dec_pc);

    // Reset in the middle of an M-read stall
    step(0, 1, 15'h0004, 0);
    chk("mst jump bubble", 64'(dec_valid), 64'(0));
    step(0, 0, 15'h0, 0);
    chk("mst stall", 64'(fstall_pre), 64'(1));
    chk("mst bubble", 64'(dec_valid), 64'(0));
    step(1, 1, 15'h0055, 0);
    chk("mst rst fetch_jmp", 64'(fjmp_pre), 64'(0));
    chk("mst rst fetch_stall", 64'(fstall_pre), 64'(0));
    chk("mst rst dec", 64'(cur_dec()), 64'(0));
    step(1, 0, 15'h0, 0);
    chk("mst rst dec2", 64'(cur_dec()), 64'(0));
    step(0, 0, 15'h0, 0);
    chk("mst fill bubble", 64'(dec_valid), 64'(0));
    step(0, 0, 15'h0, 0);
    chk("mst restart", 64'(cur_dec()), 64'(ref_dec(rom[0], 15'h0000)));
    $display("seq reset-mid-mstall: restart pc=%h", dec_pc);

    // Word 0x8000: trapped when the feature is built in, ordinary C-instruction otherwise
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
    chk("illegal clear", 64'(dec_illegal), 64'(0));
`endif
    step(0, 1, 15'h0030, 0);
    chk("ill jump bubble", 64'(dec_valid), 64'(0));
    step(0, 0, 15'h0, 0);
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
    chk("ill valid", 64'(dec_valid), 64'(0));
    chk("ill flag", 64'(dec_illegal), 64'(1));
`else
    chk("ill as C", 64'(cur_dec()), 64'(ref_dec(16'h8000, 15'h0030)));
`endif
    step(0, 0, 15'h0, 0);
    chk("ill next", 64'(cur_dec()), 64'(ref_dec(rom[15'h31], 15'h0031)));
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
    chk("ill sticky", 64'(dec_illegal), 64'(1));
`endif
    $display("seq illegal-word: next pc=%h", dec_pc);

    // Random traffic against a program-order model
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
      if (w[15]) w[14:13] = 2'b11;
`endif
      rom[i] = w;
    end
    next_pc = RST_PC;
    issued  = 0;
    for (int i = 0; i < 3000; i++) begin
      r = (i < 2) || ($urandom_range(0, 499) == 0);
      j = ($urandom_range(0, 15) == 0);
      t = 15'($urandom_range(0, 32767));
      h = ($urandom_range(0, 4) == 0);
      step(r, j, t, h);
      if (r) begin
        chk("rnd rst fetch_jmp", 64'(fjmp_pre), 64'(0));
        chk("rnd rst fetch_stall", 64'(fstall_pre), 64'(0));
        chk("rnd rst dec", 64'(cur_dec()), 64'(0));
        next_pc = RST_PC;
      end else begin
        chk("rnd fetch_jmp", 64'(fjmp_pre), 64'(j));
        if (j) begin
          chk("rnd fetch_addr", 64'(faddr_pre), 64'(t));
          chk("rnd jump bubble", 64'(dec_valid), 64'(0));
          next_pc = t;
        end else if (h) begin
          chk("rnd hold stable", 64'(cur_dec()), 64'(prev_dec));
        end else if (dec_valid) begin
          chk("rnd issue", 64'(cur_dec()), 64'(ref_dec(rom[next_pc], next_pc)));
          next_pc = next_pc + 15'd1;
          issued++;
        end
`ifdef HACK_DECODE_ILLEGAL_TRAP_EN
        chk("rnd illegal clear", 64'(dec_illegal), 64'(0));
`endif
      end
    end
    chk("rnd progress", 64'(issued >= 300), 64'(1));
    $display("random: %0d instructions issued", issued);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
